// File: rtl/whackamole_pkg.sv
// rtl/whackamole_pkg.sv - shared constants, scanner state encoding and MMIO offsets
package whackamole_pkg;

  localparam int NUM_SENSORS = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISCHARGE,
    ST_CHARGE,
    ST_EVAL
  } scan_state_t;

  localparam logic [7:0] MMIO_TOUCHED     = 8'h00;
  localparam logic [7:0] MMIO_PRESS_FLAGS = 8'h04;
  localparam logic [7:0] MMIO_PRESS_CLEAR = 8'h08;

endpackage

// File: rtl/cap_channel.sv
// rtl/cap_channel.sv - one pad: pin synchronizer, rise-time capture, threshold compare, debounce
module cap_channel #(
  parameter int COUNT_WIDTH = 16,
  parameter int MAX_COUNT   = 4000,
  parameter int DEBOUNCE    = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pin,
  input  logic                   clear_capture,
  input  logic                   charging,
  input  logic                   timeout,
  input  logic                   eval,
  input  logic [COUNT_WIDTH-1:0] charge_count,
  input  logic [COUNT_WIDTH-1:0] threshold,
  output logic                   sin,
  output logic                   captured,
  output logic                   raw,
  output logic                   db_wrap,
  output logic                   touched
);

  logic [1:0]             sync_q;
  logic [COUNT_WIDTH-1:0] count;
  logic [2:0]             db;

  assign sin     = sync_q[1];
  assign raw     = (count >= threshold);
  assign db_wrap = ((db + 3'd1) == 3'(DEBOUNCE));

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q   <= '0;
      captured <= 1'b0;
      count    <= '0;
      db       <= '0;
      touched  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin};

      // A capture on the timeout cycle takes priority over the MAX_COUNT fill.
      if (clear_capture) begin
        captured <= 1'b0;
      end else if (charging && !captured) begin
        if (sin) begin
          captured <= 1'b1;
          count    <= charge_count;
        end else if (timeout) begin
          captured <= 1'b1;
          count    <= COUNT_WIDTH'(MAX_COUNT);
        end
      end

      if (eval) begin
        if (raw == touched) begin
          db <= '0;
        end else if (db_wrap) begin
          touched <= ~touched;
          db      <= '0;
        end else begin
          db <= db + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/cap_sensor_scanner.sv
// rtl/cap_sensor_scanner.sv - drive-line sequencer and press-flag register for the capacitive pads
module cap_sensor_scanner
  import whackamole_pkg::*;
#(
  parameter int NUM_SENSORS      = whackamole_pkg::NUM_SENSORS,
  parameter int COUNT_WIDTH      = 16,
  parameter int DISCHARGE_CYCLES = 500,
  parameter int MAX_COUNT        = 4000,
  parameter int DEBOUNCE         = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] threshold,
  input  logic [NUM_SENSORS-1:0] capacitive_sensors_in,
  output logic                   capacitive_sensors_out,
  output logic [NUM_SENSORS-1:0] touched,
  output logic [NUM_SENSORS-1:0] press_flags,
  input  logic [NUM_SENSORS-1:0] press_clear,
  output logic                   scan_done,
  output logic                   busy
);

  localparam int DIS_W = $clog2(DISCHARGE_CYCLES) + 1;
  localparam logic [DIS_W-1:0]       DIS_LAST = DIS_W'(DISCHARGE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CHG_LAST = COUNT_WIDTH'(MAX_COUNT - 1);

  scan_state_t            state;
  logic [DIS_W-1:0]       dis_cnt;
  logic [COUNT_WIDTH-1:0] chg_cnt;

  logic [NUM_SENSORS-1:0] sin_v, captured_v, raw_v, db_wrap_v;
  logic charging, eval, timeout, all_captured, charge_exit, disc_ready;
  logic [NUM_SENSORS-1:0] rise_v;

  assign charging     = (state == ST_CHARGE);
  assign eval         = (state == ST_EVAL);
  assign timeout      = charging && (chg_cnt == CHG_LAST);
  // A pad whose synced pin is high this cycle is captured on this edge.
  assign all_captured = &(captured_v | sin_v);
  assign charge_exit  = charging && (all_captured || timeout);
  assign disc_ready   = (state == ST_DISCHARGE) && (dis_cnt == DIS_LAST) && !(|sin_v);
  assign rise_v       = {NUM_SENSORS{eval}} & raw_v & ~touched & db_wrap_v;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
    cap_channel #(
      .COUNT_WIDTH(COUNT_WIDTH),
      .MAX_COUNT  (MAX_COUNT),
      .DEBOUNCE   (DEBOUNCE)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .pin          (capacitive_sensors_in[i]),
      .clear_capture(state == ST_DISCHARGE),
      .charging     (charging),
      .timeout      (timeout),
      .eval         (eval),
      .charge_count (chg_cnt),
      .threshold    (threshold),
      .sin          (sin_v[i]),
      .captured     (captured_v[i]),
      .raw          (raw_v[i]),
      .db_wrap      (db_wrap_v[i]),
      .touched      (touched[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                  <= ST_IDLE;
      dis_cnt                <= '0;
      chg_cnt                <= '0;
      capacitive_sensors_out <= 1'b0;
      scan_done              <= 1'b0;
      busy                   <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state   <= ST_DISCHARGE;
            dis_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_DISCHARGE: begin
          if (disc_ready) begin
            state                  <= ST_CHARGE;
            chg_cnt                <= '0;
            capacitive_sensors_out <= 1'b1;
          end else if (dis_cnt != DIS_LAST) begin
            dis_cnt <= dis_cnt + 1'b1;
          end
        end
        ST_CHARGE: begin
          if (charge_exit) begin
            state                  <= ST_EVAL;
            capacitive_sensors_out <= 1'b0;
            scan_done              <= 1'b1;
          end else begin
            chg_cnt <= chg_cnt + 1'b1;
          end
        end
        default: begin
          dis_cnt <= '0;
          if (enable) begin
            state <= ST_DISCHARGE;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Set wins over a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset) press_flags <= '0;
    else       press_flags <= (press_flags & ~press_clear) | rise_v;
  end

endmodule

// File: tb/tb_cap_sensor_scanner.sv
// tb/tb_cap_sensor_scanner.sv - randomized self-checking bench for cap_sensor_scanner
module tb_cap_sensor_scanner;

  localparam int N    = 9;
  localparam int CW   = 16;
  localparam int DIS  = 4;
  localparam int MAXC = 64;
  localparam int DEB  = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [CW-1:0] threshold;
  logic [N-1:0]  pins;
  logic          cap_out;
  logic [N-1:0]  touched;
  logic [N-1:0]  press_flags;
  logic [N-1:0]  press_clear;
  logic          scan_done;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  int dly[N];
  bit stuck[N];
  int age = 0;

  logic [N-1:0] m_touched = '0;
  logic [N-1:0] m_flags   = '0;
  int           m_db[N];

  always #5 clock = ~clock;

  cap_sensor_scanner #(
    .NUM_SENSORS     (N),
    .COUNT_WIDTH     (CW),
    .DISCHARGE_CYCLES(DIS),
    .MAX_COUNT       (MAXC),
    .DEBOUNCE        (DEB)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .enable                (enable),
    .threshold             (threshold),
    .capacitive_sensors_in (pins),
    .capacitive_sensors_out(cap_out),
    .touched               (touched),
    .press_flags           (press_flags),
    .press_clear           (press_clear),
    .scan_done             (scan_done),
    .busy                  (busy)
  );

  // RC pad model: pin rises dly[i] cycles after the drive line goes high.
  always @(negedge clock) begin
    if (cap_out === 1'b1) age = age + 1;
    else                  age = 0;
    for (int i = 0; i < N; i++)
      pins[i] = stuck[i] | ((cap_out === 1'b1) && (age > dly[i]));
  end

  task automatic model_reset();
    m_touched = '0;
    m_flags   = '0;
    for (int i = 0; i < N; i++) m_db[i] = 0;
  endtask

  task automatic model_scan(input logic [N-1:0] pc);
    logic [N-1:0] set_v;
    set_v = '0;
    for (int i = 0; i < N; i++) begin
      int c;
      bit r;
      c = (dly[i] + 2 <= MAXC - 1) ? dly[i] + 2 : MAXC;
      r = (c >= int'(threshold));
      if (r == m_touched[i]) begin
        m_db[i] = 0;
      end else if (m_db[i] + 1 >= DEB) begin
        m_touched[i] = r;
        m_db[i]      = 0;
        if (r) set_v[i] = 1'b1;
      end else begin
        m_db[i] = m_db[i] + 1;
      end
    end
    m_flags = (m_flags & ~pc) | set_v;
  endtask

  task automatic do_scan(input logic [N-1:0] pc, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (scan_done !== 1'b1 && n < 3000);
    checks++;
    if (scan_done !== 1'b1) begin
      failures++;
      $display("FAIL %s scan_timeout got=%b want=1", tag, scan_done);
      return;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_in_eval got=%b want=1", tag, busy);
    end
    press_clear = pc;
    model_scan(pc);
    @(negedge clock);
    press_clear = '0;
    checks++;
    if (touched !== m_touched) begin
      failures++;
      $display("FAIL %s touched got=%h want=%h", tag, touched, m_touched);
    end
    checks++;
    if (press_flags !== m_flags) begin
      failures++;
      $display("FAIL %s press_flags got=%h want=%h", tag, press_flags, m_flags);
    end
    checks++;
    if (scan_done !== 1'b0) begin
      failures++;
      $display("FAIL %s scan_done_pulse got=%b want=0", tag, scan_done);
    end
  endtask

  task automatic wait_out_high(input string tag);
    int n;
    n = 0;
    while (cap_out !== 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (cap_out !== 1'b1) begin
      failures++;
      $display("FAIL %s wait_charge got=%b want=1", tag, cap_out);
    end
  endtask

  task automatic test_reset();
    int sd;
    reset = 1'b1; enable = 1'b0; threshold = 16'd20; press_clear = '0;
    for (int i = 0; i < N; i++) begin dly[i] = 5; stuck[i] = 0; end
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({cap_out, busy, scan_done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000", {cap_out, busy, scan_done});
    end
    checks++;
    if (touched !== '0 || press_flags !== '0) begin
      failures++;
      $display("FAIL reset_state touched=%h flags=%h want=0", touched, press_flags);
    end
    sd = 0;
    repeat (100) begin
      @(negedge clock);
      if (scan_done === 1'b1 || busy === 1'b1) sd++;
    end
    checks++;
    if (sd != 0) begin
      failures++;
      $display("FAIL idle_quiet got=%0d want=0", sd);
    end
  endtask

  task automatic test_untouched();
    enable = 1'b1;
    repeat (10) do_scan('0, "untouched");
    checks++;
    if (touched !== '0) begin
      failures++;
      $display("FAIL untouched_final got=%h want=0", touched);
    end
  endtask

  task automatic test_touch_pad4();
    dly[4] = 30;
    for (int s = 1; s <= 4; s++) begin
      do_scan('0, "touch4");
      if (s == 2) begin
        checks++;
        if (touched !== 9'h000) begin
          failures++;
          $display("FAIL touch4_early got=%h want=000", touched);
        end
      end
      if (s == 3) begin
        checks++;
        if (touched !== 9'h010 || press_flags !== 9'h010) begin
          failures++;
          $display("FAIL touch4_set touched=%h flags=%h want=010/010", touched, press_flags);
        end
      end
    end
    dly[4] = 5;
    for (int s = 1; s <= 3; s++) do_scan('0, "release4");
    checks++;
    if (touched !== 9'h000 || press_flags !== 9'h010) begin
      failures++;
      $display("FAIL release4 touched=%h flags=%h want=000/010", touched, press_flags);
    end
  endtask

  task automatic test_flag_clear();
    press_clear = 9'h010;
    m_flags = m_flags & ~9'h010;
    @(negedge clock);
    press_clear = '0;
    checks++;
    if (press_flags !== 9'h000) begin
      failures++;
      $display("FAIL flag_clear got=%h want=000", press_flags);
    end
    dly[4] = 30;
    do_scan('0, "setclr");
    do_scan('0, "setclr");
    do_scan(9'h010, "setclr");
    checks++;
    if (press_flags[4] !== 1'b1) begin
      failures++;
      $display("FAIL set_wins got=%b want=1", press_flags[4]);
    end
  endtask

  task automatic test_timeout();
    dly[4] = 5;
    dly[2] = 1000;
    repeat (3) do_scan('0, "timeout");
    checks++;
    if (touched[2] !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pad2 got=%b want=1", touched[2]);
    end
    dly[2] = 5;
    repeat (3) do_scan('0, "timeout_rel");
  endtask

  task automatic test_boundaries();
    threshold = 16'd64;
    dly[0] = 61;
    dly[1] = 62;
    dly[3] = 62;
    repeat (3) do_scan('0, "bound64");
    threshold = 16'd9;
    for (int i = 0; i < N; i++) dly[i] = (i % 2 == 0) ? 7 : 6;
    repeat (4) do_scan('0, "bound9");
    checks++;
    if (touched !== 9'h155) begin
      failures++;
      $display("FAIL bound9_pattern got=%h want=155", touched);
    end
    threshold = 16'd20;
    for (int i = 0; i < N; i++) dly[i] = 5;
    repeat (3) do_scan('0, "bound_rel");
  endtask

  task automatic test_stuck();
    int sd, nb;
    stuck[7] = 1;
    sd = 0; nb = 0;
    repeat (200) begin
      @(negedge clock);
      if (scan_done === 1'b1) sd++;
      if (busy !== 1'b1 || cap_out !== 1'b0) nb++;
    end
    checks++;
    if (sd != 0) begin
      failures++;
      $display("FAIL stuck_scans got=%0d want=0", sd);
    end
    checks++;
    if (nb != 0) begin
      failures++;
      $display("FAIL stuck_hold bad_cycles=%0d want=0", nb);
    end
    stuck[7] = 0;
    do_scan('0, "unstuck");
  endtask

  task automatic test_random();
    for (int s = 0; s < 25; s++) begin
      for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 70);
      threshold = CW'($urandom_range(0, 72));
      do_scan(N'($urandom), "random");
    end
  endtask

  task automatic test_enable_drop();
    int sd, nb;
    for (int i = 0; i < N; i++) dly[i] = 5;
    threshold = 16'd20;
    wait_out_high("en_drop");
    enable = 1'b0;
    do_scan('0, "en_drop");
    sd = 0; nb = 0;
    repeat (50) begin
      if (scan_done === 1'b1) sd++;
      if (busy !== 1'b0 || cap_out !== 1'b0) nb++;
      @(negedge clock);
    end
    checks++;
    if (sd != 0 || nb != 0) begin
      failures++;
      $display("FAIL en_drop_idle scans=%0d bad_cycles=%0d want=0/0", sd, nb);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    dly[0] = 40;
    wait_out_high("rst_mid");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({cap_out, busy, scan_done} !== 3'b000 || touched !== '0 || press_flags !== '0) begin
      failures++;
      $display("FAIL rst_mid out=%b busy=%b done=%b touched=%h flags=%h want=all0",
               cap_out, busy, scan_done, touched, press_flags);
    end
    reset = 1'b0;
    model_reset();
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 66);
      do_scan('0, "post_rst");
    end
  endtask

  initial begin
    pins = '0;
    test_reset();
    test_untouched();
    test_touch_pad4();
    test_flag_clear();
    test_timeout();
    test_boundaries();
    test_stuck();
    test_random();
    test_enable_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
